// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/requantization unit:
// FSM states, Unified Buffer address width and the int8 saturation helper.
package wb_pkg;

  localparam int NUM_BANKS  = 16;
  localparam int BANK_DEPTH = 16;
  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int ADDR_WIDTH = BANK_BITS + $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_e;

  // Clamp v into the signed range of a w-bit word; caller truncates to w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/requant_pipe.sv
// Requantization datapath: input capture, scale multiply, rounding shift,
// ReLU + saturation. Valid and write address travel with each beat.
module requant_pipe
  import wb_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [SCALE_WIDTH-1:0] scale_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic                   relu_i,
  input  logic                   vld_i,
  input  logic [ACC_WIDTH-1:0]   data_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic                   vld_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic                   inflight_o
);

  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH;

  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] v,
                                                           input logic [SHIFT_WIDTH-1:0] sh);
    logic signed [PROD_W-1:0] bias;
    bias = PROD_W'(1) << (sh - SHIFT_WIDTH'(1));
    if (sh == '0) return v;
    return (v + bias) >>> sh;
  endfunction

  logic signed [SCALE_WIDTH-1:0] scale_s;
  logic signed [ACC_WIDTH-1:0]   acc_p0_q;
  logic signed [PROD_W-1:0]      prod_p1_q;
  logic signed [PROD_W-1:0]      r_p2_q;
  logic signed [PROD_W-1:0]      r_relu;
  logic signed [DATA_WIDTH-1:0]  data_p3_d;
  logic signed [DATA_WIDTH-1:0]  data_p3_q;
  logic [ADDR_WIDTH-1:0]         addr_p0_q, addr_p1_q, addr_p2_q, addr_p3_q;
  logic                          vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;

  assign scale_s = scale_i;

  always_comb begin
    r_relu = r_p2_q;
    if (relu_i && r_p2_q[PROD_W-1]) r_relu = '0;
    data_p3_d = DATA_WIDTH'(sat_signed(64'(r_relu), DATA_WIDTH));
  end

  // p0 capture -> p1 product -> p2 rounded shift -> p3 saturated output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      data_p3_q <= '0;
      addr_p3_q <= '0;
    end else if (en_i) begin
      vld_p0_q  <= vld_i;
      vld_p1_q  <= vld_p0_q;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      data_p3_q <= data_p3_d;
      addr_p3_q <= addr_p2_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      acc_p0_q  <= data_i;
      addr_p0_q <= addr_i;
      prod_p1_q <= PROD_W'(acc_p0_q) * PROD_W'(scale_s);
      addr_p1_q <= addr_p0_q;
      r_p2_q    <= round_shift(prod_p1_q, shift_i);
      addr_p2_q <= addr_p1_q;
    end
  end

  assign vld_o      = vld_p3_q;
  assign data_o     = data_p3_q;
  assign addr_o     = addr_p3_q;
  // The last stage is excluded: its write retires in the same cycle the FSM leaves DRAIN.
  assign inflight_o = vld_p0_q | vld_p1_q | vld_p2_q;

endmodule

// File: rtl/writeback_requant_unit.sv
// Writeback stage for the Unified Buffer WB port: job FSM, beat and address
// counters around the requantization pipeline.
module writeback_requant_unit
  import wb_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   ASYNC_RST,
  input  logic                   EN,
  input  logic                   Start,
  input  logic [ADDR_WIDTH-1:0]  BaseAddress,
  input  logic [ADDR_WIDTH:0]    Count,
  input  logic [SCALE_WIDTH-1:0] Scale,
  input  logic [SHIFT_WIDTH-1:0] Shift,
  input  logic                   ReluEn,
  input  logic                   AccValid,
  output logic                   AccReady,
  input  logic [ACC_WIDTH-1:0]   AccData,
  output logic                   WbWriteValid,
  output logic [ADDR_WIDTH-1:0]  WbWriteAddress,
  output logic [DATA_WIDTH-1:0]  WbWriteData,
  output logic                   Busy,
  output logic                   Done
);

  wb_state_e              state_q, state_d;
  logic [ADDR_WIDTH:0]    remain_q, remain_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;
  logic                   accept;
  logic                   inflight;
  logic                   pipe_vld;

  assign AccReady = EN & (state_q == RUN) & (remain_q != '0);
  assign accept   = AccValid & AccReady;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE: begin
        if (Start && EN) begin
          remain_d = Count;
          addr_d   = BaseAddress;
          state_d  = (Count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          remain_d = remain_q - (ADDR_WIDTH + 1)'(1);
          addr_d   = addr_q + ADDR_WIDTH'(1);
          if (remain_q == (ADDR_WIDTH + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      state_q  <= IDLE;
      remain_q <= '0;
      addr_q   <= '0;
    end else if (EN) begin
      state_q  <= state_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
    end
  end

  // Job configuration is captured only when a Start is accepted.
  always_ff @(posedge CLK) begin
    if (EN && Start && state_q == IDLE) begin
      scale_q <= Scale;
      shift_q <= Shift;
      relu_q  <= ReluEn;
    end
  end

  requant_pipe #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_pipe (
    .clk_i     (CLK),
    .rst_i     (ASYNC_RST),
    .en_i      (EN),
    .scale_i   (scale_q),
    .shift_i   (shift_q),
    .relu_i    (relu_q),
    .vld_i     (accept),
    .data_i    (AccData),
    .addr_i    (addr_q),
    .vld_o     (pipe_vld),
    .data_o    (WbWriteData),
    .addr_o    (WbWriteAddress),
    .inflight_o(inflight)
  );

  assign WbWriteValid = pipe_vld & EN;
  assign Busy         = (state_q == RUN) | (state_q == DRAIN);
  assign Done         = (state_q == DONE) & EN;

endmodule
